// File: rtl/bfg_mux_test_pkg.sv
// Shared types and the golden 4:1 mux model for the mux4 comparison harness.
// The harness bench reuses this package as well as the checker.
package bfg_mux_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int VEC_W   = 6;
  localparam int NUM_VEC = 64;

  // vec[3:0] = {i3,i2,i1,i0}, vec[5:4] = {s1,s0}
  function automatic logic mux4_model(input logic [VEC_W-1:0] vec);
    logic [3:0] w_dat;
    w_dat = vec[3:0];
    return w_dat[vec[5:4]];
  endfunction

endpackage

// File: rtl/bfg_mux_sat_cnt.sv
// Saturating mismatch counter: sync clear wins over increment, holds at all-ones.
// Update visible one cycle after i_inc; no backpressure.
module bfg_mux_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/bfg_mux_checker.sv
// Sweeps all 64 mux4 vectors, samples both implementations after a settle interval
// and scores them against the golden model; one sweep takes 64*(SETTLE_CYCLES+1) cycles.
module bfg_mux_checker
  import bfg_mux_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gf_out,
  input  logic             bfg_out,
  output logic             i0,
  output logic             i1,
  output logic             i2,
  output logic             i3,
  output logic             s0,
  output logic             s1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] gf_err_cnt,
  output logic [CNT_W-1:0] bfg_err_cnt,
  output logic             fail_valid,
  output logic [5:0]       fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t             r_state;
  logic [VEC_W-1:0]   r_vec;
  logic [3:0]         r_settle;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               r_fail_valid;
  logic [VEC_W-1:0]   r_fail_vec;

  logic               w_start_ok;
  logic               w_sample;
  logic               w_exp;
  logic               w_gf_mis;
  logic               w_bfg_mis;
  logic               w_any_mis;
  logic               w_last;
  logic [CNT_W-1:0]   w_gf_cnt;
  logic [CNT_W-1:0]   w_bfg_cnt;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sample   = (r_state == ST_SAMPLE);
  assign w_exp      = mux4_model(r_vec);
  assign w_gf_mis   = w_sample && (gf_out != w_exp);
  assign w_bfg_mis  = w_sample && (bfg_out != w_exp);
  assign w_any_mis  = w_gf_mis || w_bfg_mis;
  assign w_last     = (r_vec == VEC_W'(NUM_VEC - 1));

  bfg_mux_sat_cnt #(.CNT_W(CNT_W)) u_gf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_inc (w_gf_mis),
    .o_cnt (w_gf_cnt)
  );

  bfg_mux_sat_cnt #(.CNT_W(CNT_W)) u_bfg_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_inc (w_bfg_mis),
    .o_cnt (w_bfg_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_vec        <= '0;
      r_settle     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_vec        <= '0;
            r_settle     <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Entered with r_settle=0, so this holds the vector exactly SETTLE_CYCLES cycles
          if (r_settle == SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (w_any_mis && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_vec   <= r_vec;
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_gf_cnt == '0) && (w_bfg_cnt == '0) && !w_any_mis;
            r_state <= ST_DONE;
          end else begin
            r_vec    <= r_vec + VEC_W'(1);
            r_settle <= '0;
            r_state  <= ST_SETTLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign {s1, s0, i3, i2, i1, i0} = r_vec;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign gf_err_cnt  = w_gf_cnt;
  assign bfg_err_cnt = w_bfg_cnt;
  assign fail_valid  = r_fail_valid;
  assign fail_vec    = r_fail_vec;

endmodule
